// File: rtl/cva6_clint_lite_if.sv
// rtl/cva6_clint_lite_if.sv - AXI4-Lite port bundle for the CLINT register window
interface cva6_clint_lite_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/cva6_clint_lite.sv
// rtl/cva6_clint_lite.sv - single-hart CLINT: mtime, mtimecmp, msip behind AXI4-Lite
// Optional mtime prescaler selected by CLINT_RTC_PRESCALE_EN.
module cva6_clint_lite #(
    parameter int ADDR_WIDTH = 16,
    parameter int RTC_DIV    = 50
) (
    input  logic             aclk,
    input  logic             areset,
    cva6_clint_lite_if.slave s_axi,
    output logic             timer_irq_o,
    output logic             ipi_o
);
    localparam logic [13:0] OFF_MSIP    = 14'h0000;
    localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
    localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
    localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
    localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_irq_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;
    logic        wr_en, rd_en, rtc_tick, mtime_wr;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;

    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [13:0]           wr_word, rd_word;
    logic                  unused_addr_bits;

    assign aw_addr          = s_axi.awaddr;
    assign ar_addr          = s_axi.araddr;
    assign wr_word          = aw_addr[15:2];
    assign rd_word          = ar_addr[15:2];
    assign unused_addr_bits = ^{aw_addr[1:0], ar_addr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        w_state_d = w_state_q;
        wr_en     = 1'b0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (s_axi.awvalid && s_axi.wvalid) begin
                    wr_en     = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // A software write to either mtime word replaces that cycle's increment.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = rtc_tick ? mtime_q + 64'd1 : mtime_q;
        mtime_wr   = 1'b0;
        bresp_d    = bresp_q;
        if (wr_en) begin
            bresp_d = RESP_OKAY;
            case (wr_word)
                OFF_MSIP: begin
                    if (s_axi.wstrb[0]) begin
                        msip_d = s_axi.wdata[0];
                    end
                end
                OFF_CMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], s_axi.wdata, s_axi.wstrb);
                OFF_CMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], s_axi.wdata, s_axi.wstrb);
                OFF_TIME_LO: begin
                    mtime_d  = {mtime_q[63:32], merge_bytes(mtime_q[31:0], s_axi.wdata, s_axi.wstrb)};
                    mtime_wr = 1'b1;
                end
                OFF_TIME_HI: begin
                    mtime_d  = {merge_bytes(mtime_q[63:32], s_axi.wdata, s_axi.wstrb), mtime_q[31:0]};
                    mtime_wr = 1'b1;
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end
    end

    // Reads observe next-state values so a same-cycle increment or write is visible.
    always_comb begin
        rd_val  = 32'd0;
        rd_resp = RESP_OKAY;
        case (rd_word)
            OFF_MSIP:    rd_val = {31'd0, msip_d};
            OFF_CMP_LO:  rd_val = mtimecmp_d[31:0];
            OFF_CMP_HI:  rd_val = mtimecmp_d[63:32];
            OFF_TIME_LO: rd_val = mtime_d[31:0];
            OFF_TIME_HI: rd_val = mtime_d[63:32];
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rd_en     = 1'b0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (s_axi.arvalid) begin
                    rd_en     = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = rd_resp;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

`ifdef CLINT_RTC_PRESCALE_EN
    localparam int PRESC_W = $clog2(RTC_DIV);
    logic [PRESC_W-1:0] presc_q;

    assign rtc_tick = (presc_q == PRESC_W'(RTC_DIV - 1)) && !mtime_wr;

    always_ff @(posedge aclk) begin
        if (areset || mtime_wr || (presc_q == PRESC_W'(RTC_DIV - 1))) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end
`else
    localparam int unused_rtc_div = RTC_DIV;
    logic          unused_mtime_wr;

    assign rtc_tick        = 1'b1;
    assign unused_mtime_wr = mtime_wr;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= RESP_OKAY;
            bresp_q     <= RESP_OKAY;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            bresp_q     <= bresp_d;
        end
    end

    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign timer_irq_o   = timer_irq_q;
    assign ipi_o         = msip_q;
endmodule

// File: tb/tb_cva6_clint_lite.sv
// tb/tb_cva6_clint_lite.sv - scoreboard bench for cva6_clint_lite with a cycle-count time model
module tb_cva6_clint_lite;
`ifdef CLINT_RTC_PRESCALE_EN
    localparam longint DIV = 50;
`else
    localparam longint DIV = 1;
`endif

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic irq, ipi;

    cva6_clint_lite_if #(.ADDR_WIDTH(16)) s_axi ();

    cva6_clint_lite #(.ADDR_WIDTH(16), .RTC_DIV(50)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axi       (s_axi),
        .timer_irq_o (irq),
        .ipi_o       (ipi)
    );

    always #5 aclk = ~aclk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: mtime is anchored to the edge of its last write/reset
    // and derived from elapsed edges, rather than stepped cycle by cycle.
    longint      edge_n = 0;
    longint      anch_edge = 0;
    logic [63:0] anch_val = '0;
    logic [63:0] cmp_m = '1;
    logic        msip_m = 1'b0;
    logic        cmp_flag = 1'b0;
    logic        exp_irq = 1'b0;
    logic        exp_ipi = 1'b0;
    bit          chk_en = 1'b0;
    bit          last_hw, last_hr;
    logic [1:0]  bq[$];
    rsp_t        rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] mtime_at(input longint e);
        return anch_val + 64'((e - anch_edge) / DIV);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (d & mask);
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] cur;
        logic [1:0]  resp;
        resp = 2'b00;
        case ({a[15:2], 2'b00})
            16'h0000: if (s[0]) msip_m = d[0];
            16'h4000: cmp_m[31:0]  = apply_strb(cmp_m[31:0], d, s);
            16'h4004: cmp_m[63:32] = apply_strb(cmp_m[63:32], d, s);
            16'hBFF8, 16'hBFFC: begin
                cur = mtime_at(edge_n - 1);
                if (a[2]) cur[63:32] = apply_strb(cur[63:32], d, s);
                else      cur[31:0]  = apply_strb(cur[31:0], d, s);
                anch_val  = cur;
                anch_edge = edge_n;
            end
            default: resp = 2'b10;
        endcase
        bq.push_back(resp);
    endtask

    function automatic rsp_t model_read(input logic [15:0] a);
        rsp_t r;
        logic [63:0] t;
        t = mtime_at(edge_n);
        r.resp = 2'b00;
        case ({a[15:2], 2'b00})
            16'h0000: r.data = {31'd0, msip_m};
            16'h4000: r.data = cmp_m[31:0];
            16'h4004: r.data = cmp_m[63:32];
            16'hBFF8: r.data = t[31:0];
            16'hBFFC: r.data = t[63:32];
            default: begin
                r.data = 32'd0;
                r.resp = 2'b10;
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        logic hw, hr;
        logic [15:0] wa, ra;
        logic [31:0] wd;
        logic [3:0]  ws;
        hw = s_axi.awvalid && s_axi.wvalid && s_axi.awready && s_axi.wready && !areset;
        hr = s_axi.arvalid && s_axi.arready && !areset;
        wa = s_axi.awaddr;
        wd = s_axi.wdata;
        ws = s_axi.wstrb;
        ra = s_axi.araddr;
        @(posedge aclk);
        edge_n++;
        if (areset) begin
            anch_val  = '0;
            anch_edge = edge_n;
            cmp_m     = '1;
            msip_m    = 1'b0;
            cmp_flag  = 1'b0;
            exp_irq   = 1'b0;
            exp_ipi   = 1'b0;
            bq.delete();
            rq.delete();
        end else begin
            if (hw) model_write(wa, wd, ws);
            exp_irq  = cmp_flag;
            cmp_flag = (mtime_at(edge_n) >= cmp_m);
            exp_ipi  = msip_m;
            if (hr) rq.push_back(model_read(ra));
        end
        last_hw = hw;
        last_hr = hr;
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("response_timeout", 64'(bq.size() + rq.size()), 64'd0);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lead, input bit wait_rsp);
        int n = 0;
        s_axi.awaddr  = a;
        s_axi.wdata   = d;
        s_axi.wstrb   = s;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = (aw_lead == 0);
        for (int i = 0; i < aw_lead; i++) begin
            tick();
            chk("no_write_without_wvalid", 64'(last_hw), 64'd0);
        end
        s_axi.wvalid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_hw && n < 20);
        chk("write_handshake", 64'(last_hw), 64'd1);
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        if (wait_rsp) wait_idle();
    endtask

    task automatic axi_read(input logic [15:0] a, input int hold);
        int n = 0;
        s_axi.araddr  = a;
        s_axi.arvalid = 1'b1;
        s_axi.rready  = (hold == 0);
        do begin
            tick();
            n++;
        end while (!last_hr && n < 20);
        chk("read_handshake", 64'(last_hr), 64'd1);
        s_axi.arvalid = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        s_axi.rready = 1'b1;
        wait_idle();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        chk_en = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        chk_en = 1'b1;
    endtask

    always @(negedge aclk) begin
        if (chk_en && !areset) begin
            chk("timer_irq_o", 64'(irq), 64'(exp_irq));
            chk("ipi_o", 64'(ipi), 64'(exp_ipi));
            if (s_axi.bvalid && s_axi.bready) begin
                if (bq.size() == 0) chk("unexpected_bvalid", 64'd1, 64'd0);
                else chk("bresp", 64'(s_axi.bresp), 64'(bq.pop_front()));
            end
            if (s_axi.rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    chk("rdata", 64'(s_axi.rdata), 64'(rq[0].data));
                    chk("rresp", 64'(s_axi.rresp), 64'(rq[0].resp));
                    if (s_axi.rready) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addr_tab [7];
        logic [15:0] a;
        int n;
        addr_tab = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1000, 16'h0008};
        s_axi.awaddr  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b1;
        s_axi.araddr  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b1;

        do_reset();
        chk("reset_awready", 64'(s_axi.awready), 64'd1);
        chk("reset_wready",  64'(s_axi.wready),  64'd1);
        chk("reset_arready", 64'(s_axi.arready), 64'd1);
        chk("reset_bvalid",  64'(s_axi.bvalid),  64'd0);
        chk("reset_rvalid",  64'(s_axi.rvalid),  64'd0);
        chk("reset_rdata",   64'(s_axi.rdata),   64'd0);
        chk("reset_bresp",   64'(s_axi.bresp),   64'd0);
        chk("reset_rresp",   64'(s_axi.rresp),   64'd0);
        axi_read(16'h4000, 0);
        axi_read(16'h4004, 0);
        axi_read(16'h0000, 0);

        axi_write(16'h4000, 32'd100, 4'hF, 0, 1'b1);
        axi_write(16'h4004, 32'd0, 4'hF, 0, 1'b1);
        n = 0;
        while (mtime_at(edge_n) < 64'd110 && n < 200 * int'(DIV)) begin
            tick();
            n++;
        end
        chk("irq_after_cmp_reached", 64'(irq), 64'd1);

        axi_write(16'h0000, 32'h1, 4'hF, 0, 1'b1);
        chk("ipi_set", 64'(ipi), 64'd1);
        axi_write(16'h0000, 32'h0, 4'hF, 0, 1'b1);
        chk("ipi_clear", 64'(ipi), 64'd0);

        axi_write(16'hBFFC, 32'h1234_5678, 4'hF, 0, 1'b1);
        axi_write(16'hBFF8, 32'hFFFF_FFFC, 4'hF, 0, 1'b1);
        repeat (10 * int'(DIV)) tick();
        axi_read(16'hBFFC, 0);

        axi_write(16'hBFF8, 32'hFFFF_FFF0, 4'hF, 0, 1'b1);
        axi_write(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 1'b1);
        repeat (24 * int'(DIV)) tick();
        axi_read(16'hBFFC, 0);
        axi_read(16'hBFF8, 0);
        chk("irq_after_wrap", 64'(irq), 64'd0);

        axi_write(16'h4004, 32'h0000_0001, 4'hF, 3, 1'b1);
        axi_read(16'hBFF8, 5);

        axi_write(16'h1000, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        axi_read(16'h1000, 0);

        repeat (80) begin
            n = int'($urandom_range(0, 7));
            a = (n == 7) ? 16'($urandom) : addr_tab[n];
            a = a | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), 1'b1);
            else
                axi_read(a, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) tick();
        end

        s_axi.bready = 1'b0;
        axi_write(16'h0000, 32'h1, 4'hF, 0, 1'b0);
        tick();
        chk("bvalid_pending", 64'(s_axi.bvalid), 64'd1);
        do_reset();
        s_axi.bready = 1'b1;
        tick();
        chk("bvalid_after_abort", 64'(s_axi.bvalid), 64'd0);
        chk("ipi_after_abort", 64'(ipi), 64'd0);
        axi_read(16'h0000, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cva6_clint_lite.md
# cva6_clint_lite

Core-local interruptor for the single-hart CVA6 subsystem. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit, all behind an AXI4-Lite slave. It sits directly upstream of the CVA6 wrapper and drives that wrapper's `timer_irq_i` and `ipi_in` inputs. The register window is reached from the core's `m_axi_cpu` port through the block-design interconnect.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: AXI4-Lite address width. Decode uses bits [15:0].
- `RTC_DIV`, 50: `mtime` increments once every `RTC_DIV` clock cycles. Used only when `CLINT_RTC_PRESCALE_EN` is defined. Must be ≥ 2.

Ports:
- `aclk`, in, 1: single clock for the whole block.
- `areset`, in, 1: reset, synchronous, active-high.
- `s_axi_awaddr`, in, ADDR_WIDTH; `s_axi_awvalid`, in, 1; `s_axi_awready`, out, 1: write address channel.
- `s_axi_wdata`, in, 32; `s_axi_wstrb`, in, 4; `s_axi_wvalid`, in, 1; `s_axi_wready`, out, 1: write data channel.
- `s_axi_bresp`, out, 2; `s_axi_bvalid`, out, 1; `s_axi_bready`, in, 1: write response channel.
- `s_axi_araddr`, in, ADDR_WIDTH; `s_axi_arvalid`, in, 1; `s_axi_arready`, out, 1: read address channel.
- `s_axi_rdata`, out, 32; `s_axi_rresp`, out, 2; `s_axi_rvalid`, out, 1; `s_axi_rready`, in, 1: read data channel.
- `timer_irq_o`, out, 1: level-high while `mtime >= mtimecmp`. Connects to `timer_irq_i`.
- `ipi_o`, out, 1: equals `msip[0]`. Connects to `ipi_in`.

## Operation
Register map. Byte offsets; all registers 32-bit, word-aligned, address bits [1:0] ignored.
- 0x0000 `msip`: bit 0 is R/W; bits 31:1 read 0.
- 0x4000 / 0x4004: `mtimecmp` low / high word, R/W.
- 0xBFF8 / 0xBFFC: `mtime` low / high word, R/W.
- Any other offset: writes are ignored with `bresp`=2'b10 (SLVERR); reads return 0 with `rresp`=2'b10.
- Mapped accesses return `resp`=2'b00.

Writes:
- Each byte lane updates only where its `s_axi_wstrb` bit is set.
- Write FSM states:
  - `W_IDLE`: `awready`=`wready`=1. When both `awvalid` and `wvalid` are high in the same cycle, capture the transfer, perform the write, go to `W_RESP`. One channel valid without the other: no handshake, remain in `W_IDLE`.
  - `W_RESP`: `bvalid`=1, `awready`=`wready`=0. On `bready`, go to `W_IDLE`.

Reads:
- Read FSM states:
  - `R_IDLE`: `arready`=1. On `arvalid`, register the data and go to `R_DATA`.
  - `R_DATA`: `rvalid`=1, `arready`=0. `rdata` is held stable until `rready`, then go to `R_IDLE`.
- Read and write FSMs are independent and may be active in the same cycle.

`mtime`:
- Without prescale: increments by 1 every cycle.
- Wraps from 2^64−1 to 0.
- Increment is a plain 64-bit add with full carry from low word to high word.

Interrupt compare:
- `timer_irq_o` is registered from an unsigned 64-bit compare `mtime >= mtimecmp`, evaluated on the post-update values.

## Timing
Reset values:
- `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0.
- `timer_irq_o`=0, `ipi_o`=0.
- `bvalid`=`rvalid`=0, `awready`=`wready`=`arready`=1, `rdata`=0, `bresp`=`rresp`=0.
- Both FSMs in IDLE.
- Reset asserted mid-transaction aborts it; no response is issued.

Latencies:
- Write: AW+W handshake in cycle N → register updated at end of N → `bvalid` high in N+1.
- Read: AR handshake in cycle N → `rvalid` high in N+1. Data is the register value at the end of N, including any same-cycle `mtime` increment.
- Each FSM accepts at most one transfer every 2 cycles when `bready`/`rready` are held high.

Interrupt outputs:
- `ipi_o` follows `msip` with no extra delay; it changes in the cycle after the write handshake.
- `timer_irq_o` changes 1 cycle after the comparison result changes.

Simultaneous events:
- A software write to an `mtime` word in the same cycle as an increment: the written bytes take the written value and no increment is applied that cycle. The unwritten word keeps its old value.
- A write to `mtimecmp` that lowers it to ≤ `mtime` raises `timer_irq_o` 1 cycle later.
- A write that raises `mtimecmp` above `mtime` clears `timer_irq_o` 1 cycle later.

## Configuration
`CLINT_RTC_PRESCALE_EN`:
- Defined: a prescale counter counts from 0 to `RTC_DIV`−1. `mtime` increments only in the cycle the counter wraps.
  - The counter resets to 0.
  - Any write to an `mtime` word also clears the counter to 0.
- Undefined: no prescale counter is built, and `mtime` increments every `aclk` cycle. `RTC_DIV` is unused.

## Test plan
- Reset, then read 0x4000, 0x4004, 0x0000 → 0xFFFFFFFF, 0xFFFFFFFF, 0x0; `timer_irq_o`=0, `ipi_o`=0.
- Write 0x1 to 0x0000 → `ipi_o`=1 one cycle after the handshake. Write 0x0 → `ipi_o`=0.
- Write `mtimecmp` = 100 (low word, then 0 to high word), no prescale → `timer_irq_o` rises exactly 1 cycle after `mtime` reaches 100 and stays high.
- Write 0xFFFFFFF0 to 0xBFF8 and 0xFFFFFFFF to 0xBFFC → `mtime` wraps to 0 after 16 cycles, low-to-high carry is correct, and `timer_irq_o` drops.
- Present `awvalid` 3 cycles before `wvalid`; hold `rready`=0 for 5 cycles on a read of 0xBFF8 → write completes only once both are valid; `rdata` stays stable until `rready`.
- Access 0x1000 → write ignored with `bresp`=2'b10; read returns 0 with `rresp`=2'b10. With `CLINT_RTC_PRESCALE_EN`, `RTC_DIV`=50 → `mtime` advances by 2 in 100 cycles.
